// File: rtl/dmem_lsu.sv
// Word-organised data memory behind a load/store front end. Handles byte, half and word access,
// detects faults, and adds optional wait states before the single-cycle response strobe.
//
// state  | meaning
// S_IDLE | no access outstanding, ready for a request
// S_WAIT | access accepted, counting down wait states
// S_RESP | response strobe cycle; a new request may be accepted
module dmem_lsu #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              accept;
  logic              fault;
  logic [ADDR_W-3:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       rword;
  logic [31:0]       rshift;
  logic [31:0]       load_ext;
  logic [31:0]       rdata_q;
  logic              err_q;

  assign ready_o   = (state_q != S_WAIT);
  assign accept    = req_i && ready_o;
  assign word_addr = addr_i[ADDR_W-1:2];
  assign idx       = addr_i[IDX_W+1:2];
  assign lane      = addr_i[1:0];

  always_comb begin
    fault = 1'b0;
    case (size_i)
      2'b00:   fault = 1'b0;
      2'b01:   fault = lane[0];
      2'b10:   fault = (lane != 2'b00);
      default: fault = 1'b1;
    endcase
    if (word_addr >= (ADDR_W-2)'(DEPTH_WORDS)) fault = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata_i;
    case (size_i)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign rword  = mem[idx];
  assign rshift = rword >> {lane, 3'b000};

  always_comb begin
    load_ext = rword;
    case (size_i)
      2'b00:   load_ext = {{24{~unsigned_i & rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = {{16{~unsigned_i & rshift[15]}}, rshift[15:0]};
      default: load_ext = rword;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept && we_i && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load result is formed at accept so a later store cannot disturb it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (fault || we_i) ? 32'd0 : load_ext;
      err_q   <= fault;
    end
  end

  assign rvalid_o = (state_q == S_RESP);
  assign rdata_o  = rvalid_o ? rdata_q : 32'd0;
  assign err_o    = rvalid_o & err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench: two LSU instances (0 and 3 wait states) checked against a byte-level memory model.
module tb_dmem_lsu;

  localparam int DEPTH  = 64;
  localparam int ABYTES = 4 * DEPTH;

  typedef struct packed {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn   [2];
  logic        req    [2];
  logic        we     [2];
  logic [1:0]  size   [2];
  logic        uns    [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ready  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  logic [7:0]  bm [2][ABYTES];
  exp_t        q0[$];
  exp_t        q1[$];
  int          nchk  = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .RSTn(rstn[0]), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .unsigned_i(uns[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
  );

  dmem_lsu #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .CLK(clk), .RSTn(rstn[1]), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .unsigned_i(uns[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, access = nbytes consecutive bytes, little endian.
  task automatic model(bit k, logic w, logic [1:0] sz, logic u, logic [31:0] a,
                       logic [31:0] wd, output exp_t e);
    int nb;
    logic [31:0] v;
    logic [31:0] p;
    nb   = 1 << sz;
    v    = 32'd0;
    e.rd = 32'd0;
    e.er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
           || (a >= 32'(ABYTES));
    if (!e.er) begin
      for (int i = 0; i < nb; i++) begin
        p = a + 32'(i);
        if (w) bm[k][p[7:0]] = wd[8*i +: 8];
        else   v[8*i +: 8]  = bm[k][p[7:0]];
      end
      if (!w) begin
        if (nb < 4 && !u && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        e.rd = v;
      end
    end
  endtask

  task automatic do_acc(bit k, logic w, logic [1:0] sz, logic u, logic [31:0] a,
                        logic [31:0] wd);
    int   budget;
    exp_t e;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; size[k] = sz; uns[k] = u; addr[k] = a; wdata[k] = wd;
    budget = 0;
    while (!ready[k] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("accept_ready", 64'(ready[k]), 64'd1);
    if (ready[k]) begin
      model(k, w, sz, u, a, wd, e);
      if (k == 1'b0) q0.push_back(e);
      else           q1.push_back(e);
      @(posedge clk);
    end
    #1 req[k] = 1'b0;
  endtask

  task automatic drain(bit k);
    int budget = 0;
    while (((k == 1'b0) ? q0.size() : q1.size()) != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("drain", 64'((k == 1'b0) ? q0.size() : q1.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rstn[k]) begin
        if (rvalid[k]) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_rvalid: inst %0d got rvalid 1 expected no response", k);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk(k == 0 ? "rdata_0" : "rdata_3", 64'(rdata[k]), 64'(e.rd));
            chk(k == 0 ? "err_0" : "err_3", 64'(err[k]), 64'(e.er));
          end
        end else begin
          chk("idle_outputs", {31'd0, err[k], rdata[k]}, 64'd0);
        end
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; size[k] = 2'd0;
      uns[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 64'(ready[k]), 64'd1);
      chk("rst_outputs", {31'd0, rvalid[k], rdata[k]}, 64'd0);
      chk("rst_err", 64'(err[k]), 64'd0);
    end
    repeat (2) @(negedge clk);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < DEPTH; w++) do_acc(1'(k), 1'b1, 2'd2, 1'b0, 32'(4*w), $urandom);
      drain(1'(k));
    end

    // word store/load, then a sub-word store merged into it
    do_acc(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_00F0);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("lw_latency", 64'(rvalid[0]), 64'd1);
    do_acc(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h1234_56AB);
    do_acc(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    do_acc(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    do_acc(0, 1'b0, 2'd2, 1'b1, 32'h10, 32'd0);
    do_acc(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    // faults: misaligned half, out-of-range store, illegal size
    do_acc(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'd0);
    do_acc(0, 1'b1, 2'd2, 1'b0, 32'(ABYTES), 32'hDEAD_BEEF);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    do_acc(0, 1'b1, 2'd3, 1'b0, 32'h4, 32'h5555_5555);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0);
    drain(0);

    // back-to-back store then load of the same word
    do_acc(0, 1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFE_1234);
    chk("b2b_rvalid_store", 64'(rvalid[0]), 64'd1);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
    chk("b2b_rvalid_load", 64'(rvalid[0]), 64'd1);
    drain(0);

    // three wait states
    do_acc(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ws_ready_low", 64'(ready[1]), 64'd0);
      chk("ws_no_rvalid", 64'(rvalid[1]), 64'd0);
    end
    @(negedge clk);
    chk("ws_rvalid", 64'(rvalid[1]), 64'd1);
    chk("ws_ready_back", 64'(ready[1]), 64'd1);
    drain(1);

    // reset while waiting drops the load but keeps the earlier store
    do_acc(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678);
    drain(1);
    do_acc(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    @(posedge clk);
    #1 rstn[1] = 1'b0;
    #1;
    chk("rst_wait_ready", 64'(ready[1]), 64'd1);
    chk("rst_wait_outputs", {31'd0, rvalid[1], rdata[1]}, 64'd0);
    chk("rst_wait_err", 64'(err[1]), 64'd0);
    q1.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_rvalid", 64'(rvalid[1]), 64'd0);
    end
    rstn[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 64'(rvalid[1]), 64'd0);
    end
    do_acc(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    drain(1);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 150; n++) begin
        r  = int'($urandom % 16);
        sz = (r == 0) ? 2'd3 : 2'(r % 3);
        if ($urandom % 8 == 0) a = 32'(ABYTES) + ($urandom % 4096);
        else                   a = $urandom % 256;
        if ($urandom % 4 != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
        do_acc(1'(k), 1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom);
        repeat ($urandom % 3) @(negedge clk);
      end
      drain(1'(k));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
